// File: rtl/systolic_result_drain.sv
// Run controller for an NxN output-stationary systolic array: clear, feed, snapshot,
// then stream the accumulators row-major over a valid/ready port.
module systolic_result_drain #(
  parameter int DATA_SIZE  = 8,
  parameter int N          = 3,
  parameter int RUN_CYCLES = 3*N+1,
  parameter int OUT_W      = 2*DATA_SIZE+1,
  localparam int ACC_W     = 2*DATA_SIZE+1,
  localparam int NUM_PE    = N*N,
  localparam int IDX_W     = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [NUM_PE*ACC_W-1:0] c_flat,
  output logic                    arr_clr,
  output logic                    feed_en,
  output logic                    busy,
  output logic [OUT_W-1:0]        out_data,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    out_sat,
  output logic                    done
);

  localparam int RUN_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, CAPTURE, DRAIN} state_t;

  state_t           state_reg;
  logic [RUN_W-1:0] run_cnt_reg;
  logic [ACC_W-1:0] c_arr    [NUM_PE];
  logic [ACC_W-1:0] snap_reg [NUM_PE];
  logic [ACC_W-1:0] sel_acc;
  logic [OUT_W-1:0] sel_data;
  logic             sel_sat;
  logic [IDX_W-1:0] next_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PE; gi++) begin : g_pe
      assign c_arr[gi] = c_flat[gi*ACC_W +: ACC_W];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          snap_reg[gi] <= '0;
        end else if (state_reg == CAPTURE) begin
          snap_reg[gi] <= c_arr[gi];
        end
      end
    end
  endgenerate

  assign next_idx = out_idx + 1'b1;

  // The first beat is taken straight from the array on the capture edge, since the
  // snapshot is being written on that same edge; later beats come from the snapshot.
  always_comb begin
    sel_acc = c_arr[0];
    if (state_reg == DRAIN && !out_last) begin
      sel_acc = snap_reg[next_idx];
    end
  end

  generate
    if (OUT_W >= ACC_W) begin : g_wide
      assign sel_data = OUT_W'(sel_acc);
      assign sel_sat  = 1'b0;
    end else begin : g_narrow
      assign sel_sat  = |sel_acc[ACC_W-1:OUT_W];
      assign sel_data = sel_sat ? {OUT_W{1'b1}} : sel_acc[OUT_W-1:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      run_cnt_reg <= '0;
      arr_clr     <= 1'b0;
      feed_en     <= 1'b0;
      busy        <= 1'b0;
      out_data    <= '0;
      out_idx     <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_sat     <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= CLEAR;
            arr_clr   <= 1'b1;
            busy      <= 1'b1;
          end
        end
        CLEAR: begin
          state_reg   <= RUN;
          arr_clr     <= 1'b0;
          feed_en     <= 1'b1;
          run_cnt_reg <= '0;
        end
        RUN: begin
          if (run_cnt_reg == RUN_W'(RUN_CYCLES-1)) begin
            state_reg <= CAPTURE;
            feed_en   <= 1'b0;
          end else begin
            run_cnt_reg <= run_cnt_reg + 1'b1;
          end
        end
        CAPTURE: begin
          state_reg <= DRAIN;
          out_valid <= 1'b1;
          out_data  <= sel_data;
          out_sat   <= sel_sat;
          out_idx   <= '0;
          out_last  <= (NUM_PE == 1);
        end
        DRAIN: begin
          if (out_ready) begin
            if (out_last) begin
              state_reg <= IDLE;
              out_valid <= 1'b0;
              out_data  <= '0;
              out_sat   <= 1'b0;
              out_idx   <= '0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              out_idx  <= next_idx;
              out_data <= sel_data;
              out_sat  <= sel_sat;
              out_last <= (next_idx == IDX_W'(NUM_PE-1));
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Bench for systolic_result_drain: a full-width and a saturating (OUT_W=16) instance share
// stimulus; a run-level model predicts the stream from the value present at capture time.
module tb_systolic_result_drain;

  localparam int DS    = 8;
  localparam int N     = 3;
  localparam int NN    = N*N;
  localparam int RUN   = 3*N+1;
  localparam int ACC_W = 2*DS+1;
  localparam int OW_S  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic out_ready = 1'b0;
  logic [NN*ACC_W-1:0] c_flat = '0;

  logic a_clr, a_feed, a_busy, a_valid, a_last, a_sat, a_done;
  logic [ACC_W-1:0] a_data;
  logic [3:0] a_idx;
  logic b_clr, b_feed, b_busy, b_valid, b_last, b_sat, b_done;
  logic [OW_S-1:0] b_data;
  logic [3:0] b_idx;

  systolic_result_drain #(.DATA_SIZE(DS), .N(N), .RUN_CYCLES(RUN), .OUT_W(ACC_W)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .c_flat(c_flat),
    .arr_clr(a_clr), .feed_en(a_feed), .busy(a_busy), .out_data(a_data), .out_idx(a_idx),
    .out_valid(a_valid), .out_ready(out_ready), .out_last(a_last), .out_sat(a_sat), .done(a_done)
  );

  systolic_result_drain #(.DATA_SIZE(DS), .N(N), .RUN_CYCLES(RUN), .OUT_W(OW_S)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .c_flat(c_flat),
    .arr_clr(b_clr), .feed_en(b_feed), .busy(b_busy), .out_data(b_data), .out_idx(b_idx),
    .out_valid(b_valid), .out_ready(out_ready), .out_last(b_last), .out_sat(b_sat), .done(b_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int cyc;
    bit clr, feed, busy, valid, last, done;
    int idx;
    int data;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OW_S-1:0] exp16(input logic [ACC_W-1:0] v);
    return (v[ACC_W-1:OW_S] != 0) ? {OW_S{1'b1}} : v[OW_S-1:0];
  endfunction

  task automatic rand_c;
    for (int k = 0; k < NN; k++) c_flat[k*ACC_W +: ACC_W] = ACC_W'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a_ctrl"}, {a_clr, a_feed, a_busy, a_valid, a_last, a_sat, a_done}, 0);
    check({tag, "_a_data"}, {a_data, a_idx}, 0);
    check({tag, "_b_ctrl"}, {b_clr, b_feed, b_busy, b_valid, b_last, b_sat, b_done}, 0);
    check({tag, "_b_data"}, {b_data, b_idx}, 0);
  endtask

  // mode 0: ready high, fixed c_flat; 1: 3-cycle stall at beat 4; 2: random ready and data;
  // 3: as 2 plus c_flat churn and start pulses while draining; 4: reset after beat 2.
  task automatic do_run(input int mode);
    logic [ACC_W-1:0] snap [NN];
    int acc_cnt;
    int stall;
    int cyc;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 1; c <= RUN + 2; c++) begin
      if (mode >= 2) rand_c;
      check("arr_clr", a_clr, (c == 1));
      check("feed_en", a_feed, (c >= 2 && c <= RUN + 1));
      check("busy_run", {a_busy, b_busy}, 2'b11);
      check("valid_run", {a_valid, b_valid}, 2'b00);
      if (c == RUN + 2)
        for (int k = 0; k < NN; k++) snap[k] = c_flat[k*ACC_W +: ACC_W];
      tick;
    end
    acc_cnt = 0;
    stall = 0;
    cyc = 0;
    while (acc_cnt < NN && cyc < 200) begin
      case (mode)
        1: begin
          out_ready = !(acc_cnt == 4 && stall < 3);
          if (!out_ready) stall++;
        end
        2, 3: out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b1;
      endcase
      if (mode == 3) begin
        rand_c;
        start = $urandom_range(0, 1);
      end
      if (mode == 4 && acc_cnt == 2) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        tick;
        check("abort_done", {a_done, b_done}, 2'b00);
        rst_n = 1'b1;
        tick;
        check("abort_idle", {a_busy, a_done, b_busy, b_done}, 4'b0000);
        $display("run aborted after %0d beats", acc_cnt);
        return;
      end
      check("valid", {a_valid, b_valid}, 2'b11);
      check("idx", {a_idx, b_idx}, {acc_cnt[3:0], acc_cnt[3:0]});
      check("data_a", a_data, snap[acc_cnt]);
      check("sat_a", a_sat, 0);
      check("data_b", b_data, exp16(snap[acc_cnt]));
      check("sat_b", b_sat, (snap[acc_cnt][ACC_W-1:OW_S] != 0));
      check("last", {a_last, b_last}, {2{acc_cnt == NN - 1}});
      check("done_drain", {a_done, b_done}, 2'b00);
      if (out_ready) begin
        $display("beat idx %0d data %0h sat16 %0h/%0d", acc_cnt, a_data, b_data, b_sat);
        acc_cnt++;
      end
      tick;
      cyc++;
    end
    start = 1'b0;
    check("drain_beats", acc_cnt, NN);
    check("done_pulse", {a_done, b_done}, 2'b11);
    check("busy_end", {a_busy, b_busy, a_valid, b_valid}, 4'b0000);
    if (mode == 3) begin
      for (int c = 0; c < 6; c++) begin
        tick;
        check("no_requeue", {a_busy, a_done, a_clr, b_busy}, 4'b0000);
      end
    end
  endtask

  vec_t tbl [13];
  int ti;

  initial begin
    tbl[0]  = '{0,  0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1,  1, 0, 1, 0, 0, 0, 0, 0};
    tbl[2]  = '{2,  0, 1, 1, 0, 0, 0, 0, 0};
    tbl[3]  = '{7,  0, 1, 1, 0, 0, 0, 0, 0};
    tbl[4]  = '{11, 0, 1, 1, 0, 0, 0, 0, 0};
    tbl[5]  = '{12, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[6]  = '{13, 0, 0, 1, 1, 0, 0, 0, 100};
    tbl[7]  = '{14, 0, 0, 1, 1, 0, 0, 1, 200};
    tbl[8]  = '{17, 0, 0, 1, 1, 0, 0, 4, 500};
    tbl[9]  = '{20, 0, 0, 1, 1, 0, 0, 7, 800};
    tbl[10] = '{21, 0, 0, 1, 1, 1, 0, 8, 900};
    tbl[11] = '{22, 0, 0, 0, 0, 0, 1, 0, 0};
    tbl[12] = '{23, 0, 0, 0, 0, 0, 0, 0, 0};

    for (int k = 0; k < NN; k++) c_flat[k*ACC_W +: ACC_W] = ACC_W'(100 * (k + 1));
    tick;
    tick;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick;

    // Latency and stream order with ready held high
    out_ready = 1'b1;
    ti = 0;
    for (int c = 0; c <= 23; c++) begin
      start = (c == 0);
      if (ti < 13 && tbl[ti].cyc == c) begin
        check("tbl_clr", a_clr, tbl[ti].clr);
        check("tbl_feed", a_feed, tbl[ti].feed);
        check("tbl_busy", a_busy, tbl[ti].busy);
        check("tbl_valid", a_valid, tbl[ti].valid);
        check("tbl_last", a_last, tbl[ti].last);
        check("tbl_done", a_done, tbl[ti].done);
        check("tbl_idx", a_idx, tbl[ti].idx);
        check("tbl_data", a_data, tbl[ti].data);
        $display("table cycle %0d idx %0d data %0d", c, a_idx, a_data);
        ti++;
      end
      tick;
    end
    check("tbl_entries", ti, 13);

    do_run(1);

    rand_c;
    c_flat[0*ACC_W +: ACC_W] = 17'h1_0005;
    c_flat[1*ACC_W +: ACC_W] = 17'h0_1234;
    do_run(0);

    do_run(3);
    do_run(4);
    do_run(0);
    for (int r = 0; r < 5; r++) do_run(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
